regfile_scoreboard: RTL and testbench

- Parametrised successor to the 16x16 register file.
- Provides configurable width and depth, two combinational read ports and one write port.
- Adds an optional hardwired-zero register 0, optional write-to-read bypass, and a per-register busy scoreboard with a registered busy count.
- Sits between decode/issue (reads sources, reserves destination) and writeback (commits results, releases reservations).

---
 rtl/regfile_scoreboard_if.sv | 32 +++
 rtl/regfile_scoreboard.sv | 75 +++++++
 tb/tb_regfile_scoreboard.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Issue/writeback bus for the register file scoreboard.
// The master drives the requests and the slave returns read data, busy flags and the count.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg_no;
  logic [DATA_W-1:0] input_data;
  logic [ADDR_W-1:0] read_reg_1;
  logic [ADDR_W-1:0] read_reg_2;
  logic [DATA_W-1:0] reg_1_data;
  logic [DATA_W-1:0] reg_2_data;
  logic              busy_1;
  logic              busy_2;
  logic              reserve;
  logic [ADDR_W-1:0] reserve_reg_no;
  logic              reserve_ok;
  logic [ADDR_W:0]   busy_count;

  modport master (
    output reg_write, write_reg_no, input_data, read_reg_1, read_reg_2,
           reserve, reserve_reg_no,
    input  reg_1_data, reg_2_data, busy_1, busy_2, reserve_ok, busy_count
  );

  modport slave (
    input  reg_write, write_reg_no, input_data, read_reg_1, read_reg_2,
           reserve, reserve_reg_no,
    output reg_1_data, reg_2_data, busy_1, busy_2, reserve_ok, busy_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two combinational read ports and one write port.
// It also keeps a per-register busy scoreboard with a registered population count.
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic                   clk,
  input logic                   clear,
  regfile_scoreboard_if.slave   bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_count_q, busy_count_d;

  logic wr_en, fwd_1, fwd_2, fwd_rsv, rsv_zero, waw, mark_en, inc, dec;
  logic busy_1_c, busy_2_c;

  always_comb begin
    wr_en    = bus.reg_write && !(ZERO_REG != 0 && bus.write_reg_no == '0);
    fwd_1    = BYPASS != 0 && bus.reg_write && bus.write_reg_no == bus.read_reg_1;
    fwd_2    = BYPASS != 0 && bus.reg_write && bus.write_reg_no == bus.read_reg_2;
    fwd_rsv  = BYPASS != 0 && bus.reg_write && bus.write_reg_no == bus.reserve_reg_no;
    rsv_zero = ZERO_REG != 0 && bus.reserve_reg_no == '0;

    busy_1_c = busy_q[bus.read_reg_1] && !fwd_1;
    busy_2_c = busy_q[bus.read_reg_2] && !fwd_2;
    if (ZERO_REG != 0 && bus.read_reg_1 == '0) busy_1_c = 1'b0;
    if (ZERO_REG != 0 && bus.read_reg_2 == '0) busy_2_c = 1'b0;

    // A release of the same register in this cycle retires the old producer,
    // so it does not count as a write-after-write hazard.
    waw     = busy_q[bus.reserve_reg_no] && !fwd_rsv;
    mark_en = bus.reserve && !clear && !rsv_zero && !busy_1_c && !busy_2_c && !waw;

    inc = mark_en && !busy_q[bus.reserve_reg_no];
    dec = bus.reg_write && busy_q[bus.write_reg_no]
          && !(mark_en && bus.reserve_reg_no == bus.write_reg_no);

    busy_d = busy_q;
    if (bus.reg_write) busy_d[bus.write_reg_no] = 1'b0;
    if (mark_en)       busy_d[bus.reserve_reg_no] = 1'b1;
    busy_count_d = busy_count_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};

    for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
    if (wr_en) regs_d[bus.write_reg_no] = bus.input_data;
  end

  always_comb begin
    bus.reg_1_data = (fwd_1 && wr_en) ? bus.input_data : regs_q[bus.read_reg_1];
    bus.reg_2_data = (fwd_2 && wr_en) ? bus.input_data : regs_q[bus.read_reg_2];
    if (ZERO_REG != 0 && bus.read_reg_1 == '0) bus.reg_1_data = '0;
    if (ZERO_REG != 0 && bus.read_reg_2 == '0) bus.reg_2_data = '0;
    bus.busy_1     = busy_1_c;
    bus.busy_2     = busy_2_c;
    bus.reserve_ok = mark_en || (bus.reserve && !clear && rsv_zero);
    bus.busy_count = busy_count_q;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: three parameter variants driven by directed vectors.
// Expectations are queued with the cycle they apply to; a monitor compares them on the falling edge.
module tb_regfile_scoreboard;
  localparam int S_RD1 = 0, S_RD2 = 1, S_B1 = 2, S_B2 = 3, S_ROK = 4, S_CNT = 5;

  typedef struct {
    int          cyc;
    int          dut;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic  clk = 1'b0;
  logic  clear = 1'b0;
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;
  exp_t  q[$];

  regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(4)) if_a ();
  regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(4)) if_b ();
  regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(4)) if_z ();

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1))
    u_a (.clk(clk), .clear(clear), .bus(if_a));
  regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0))
    u_b (.clk(clk), .clear(clear), .bus(if_b));
  regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1))
    u_z (.clk(clk), .clear(clear), .bus(if_z));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] actual(int d, int s);
    logic [31:0] v;
    v = '0;
    case (d)
      0: case (s)
           S_RD1: v = 32'(if_a.reg_1_data);
           S_RD2: v = 32'(if_a.reg_2_data);
           S_B1:  v = 32'(if_a.busy_1);
           S_B2:  v = 32'(if_a.busy_2);
           S_ROK: v = 32'(if_a.reserve_ok);
           default: v = 32'(if_a.busy_count);
         endcase
      1: case (s)
           S_RD1: v = 32'(if_b.reg_1_data);
           S_RD2: v = 32'(if_b.reg_2_data);
           S_B1:  v = 32'(if_b.busy_1);
           S_B2:  v = 32'(if_b.busy_2);
           S_ROK: v = 32'(if_b.reserve_ok);
           default: v = 32'(if_b.busy_count);
         endcase
      default: case (s)
           S_RD1: v = 32'(if_z.reg_1_data);
           S_RD2: v = 32'(if_z.reg_2_data);
           S_B1:  v = 32'(if_z.busy_1);
           S_B2:  v = 32'(if_z.busy_2);
           S_ROK: v = 32'(if_z.reserve_ok);
           default: v = 32'(if_z.busy_count);
         endcase
    endcase
    return v;
  endfunction

  // Monitor: pop every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = actual(e.dut, e.sig);
      vectors++;
      if (act !== e.val) begin
        miscompares++;
        $display("FAIL %s (dut %0d, cycle %0d): got 0x%0h, expected 0x%0h",
                 e.name, e.dut, e.cyc, act, e.val);
      end
    end
  end

  task automatic expect_v(int d, int s, logic [31:0] v, string n);
    q.push_back('{cyc, d, s, v, n});
  endtask

  // One cycle of stimulus to DUT d; the other two see idle inputs.
  task automatic step(int d, bit clr, bit rw, logic [3:0] wrn, logic [15:0] din,
                      logic [3:0] r1, logic [3:0] r2, bit res, logic [3:0] rn);
    @(posedge clk);
    #1;
    clear = clr;
    if_a.reg_write = (d == 0) && rw;  if_a.write_reg_no = wrn;  if_a.input_data = din;
    if_a.read_reg_1 = r1;  if_a.read_reg_2 = r2;
    if_a.reserve = (d == 0) && res;   if_a.reserve_reg_no = rn;
    if_b.reg_write = (d == 1) && rw;  if_b.write_reg_no = wrn;  if_b.input_data = din;
    if_b.read_reg_1 = r1;  if_b.read_reg_2 = r2;
    if_b.reserve = (d == 1) && res;   if_b.reserve_reg_no = rn;
    if_z.reg_write = (d == 2) && rw;  if_z.write_reg_no = wrn;  if_z.input_data = din;
    if_z.read_reg_1 = r1;  if_z.read_reg_2 = r2;
    if_z.reserve = (d == 2) && res;   if_z.reserve_reg_no = rn;
  endtask

  initial begin
    step(0, 1, 0, 0, 16'h0, 0, 0, 0, 0);

    // Reset state and basic write/read
    step(0, 0, 1, 3, 16'h1234, 0, 0, 0, 0);
    expect_v(0, S_RD1, 32'h0, "reset_rd1");
    expect_v(0, S_B1,  32'h0, "reset_busy1");
    expect_v(0, S_CNT, 32'h0, "reset_count");
    step(0, 0, 0, 0, 16'h0, 3, 5, 0, 0);
    expect_v(0, S_RD1, 32'h1234, "read_r3");
    expect_v(0, S_RD2, 32'h0, "read_r5");
    expect_v(0, S_CNT, 32'h0, "count_after_write");

    // Bypass vs no bypass
    step(0, 0, 1, 7, 16'hBEEF, 7, 0, 0, 0);
    expect_v(0, S_RD1, 32'hBEEF, "bypass_same_cycle");
    step(1, 0, 1, 7, 16'hBEEF, 7, 0, 0, 0);
    expect_v(1, S_RD1, 32'h0, "nobypass_old_value");
    step(1, 0, 0, 0, 16'h0, 7, 0, 0, 0);
    expect_v(1, S_RD1, 32'hBEEF, "nobypass_next_cycle");

    // Hardwired zero register
    step(2, 0, 1, 0, 16'hFFFF, 0, 0, 0, 0);
    expect_v(2, S_RD1, 32'h0, "zero_write_bypass");
    step(2, 0, 0, 0, 16'h0, 0, 0, 1, 0);
    expect_v(2, S_RD1, 32'h0, "zero_read");
    expect_v(2, S_ROK, 32'h1, "zero_reserve_ok");
    step(2, 0, 0, 0, 16'h0, 0, 0, 0, 0);
    expect_v(2, S_CNT, 32'h0, "zero_count");
    expect_v(2, S_B1,  32'h0, "zero_busy");

    // RAW hazard and release
    step(0, 0, 0, 0, 16'h0, 0, 0, 1, 2);
    expect_v(0, S_ROK, 32'h1, "reserve_r2_ok");
    step(0, 0, 0, 0, 16'h0, 2, 0, 1, 4);
    expect_v(0, S_CNT, 32'h1, "count_r2");
    expect_v(0, S_B1,  32'h1, "raw_busy1");
    expect_v(0, S_ROK, 32'h0, "raw_reserve_blocked");
    step(0, 0, 1, 2, 16'h0055, 2, 0, 1, 4);
    expect_v(0, S_B1,  32'h0, "release_bypass_busy1");
    expect_v(0, S_ROK, 32'h1, "release_reserve_ok");
    expect_v(0, S_RD1, 32'h0055, "release_data_bypass");
    step(0, 0, 0, 0, 16'h0, 2, 4, 0, 0);
    expect_v(0, S_CNT, 32'h1, "count_swap");
    expect_v(0, S_B1,  32'h0, "r2_free");
    expect_v(0, S_B2,  32'h1, "r4_busy");
    expect_v(0, S_RD1, 32'h0055, "r2_data");

    // Release and re-reserve of the same register: set wins
    step(0, 0, 0, 0, 16'h0, 0, 0, 1, 6);
    expect_v(0, S_ROK, 32'h1, "reserve_r6_ok");
    step(0, 0, 1, 6, 16'h6666, 0, 0, 1, 6);
    expect_v(0, S_CNT, 32'h2, "count_r4_r6");
    expect_v(0, S_ROK, 32'h1, "waw_masked_ok");
    step(0, 0, 0, 0, 16'h0, 6, 4, 0, 0);
    expect_v(0, S_B1,  32'h1, "r6_still_busy");
    expect_v(0, S_B2,  32'h1, "r4_still_busy");
    expect_v(0, S_RD1, 32'h6666, "r6_data");
    expect_v(0, S_CNT, 32'h2, "count_unchanged");

    // Drain, non-busy release, then refill and clear
    step(0, 0, 1, 4, 16'h4444, 0, 0, 0, 0);
    step(0, 0, 1, 6, 16'h0006, 0, 0, 0, 0);
    expect_v(0, S_CNT, 32'h1, "count_after_r4_release");
    step(0, 0, 1, 3, 16'h3333, 0, 0, 0, 0);
    expect_v(0, S_CNT, 32'h0, "count_after_r6_release");
    step(0, 0, 0, 0, 16'h0, 0, 0, 1, 1);
    expect_v(0, S_CNT, 32'h0, "nonbusy_release_no_dec");
    expect_v(0, S_ROK, 32'h1, "reserve_r1_ok");
    step(0, 0, 0, 0, 16'h0, 0, 0, 1, 2);
    expect_v(0, S_ROK, 32'h1, "reserve_r2b_ok");
    step(0, 0, 0, 0, 16'h0, 0, 0, 1, 9);
    expect_v(0, S_ROK, 32'h1, "reserve_r9_ok");
    expect_v(0, S_CNT, 32'h2, "count_two");
    step(0, 0, 0, 0, 16'h0, 0, 0, 1, 9);
    expect_v(0, S_ROK, 32'h0, "waw_blocked");
    expect_v(0, S_CNT, 32'h3, "count_three");
    step(0, 1, 1, 1, 16'hAAAA, 0, 0, 1, 5);
    expect_v(0, S_ROK, 32'h0, "clear_blocks_reserve");
    expect_v(0, S_CNT, 32'h3, "count_before_clear");
    step(0, 0, 0, 0, 16'h0, 1, 9, 0, 0);
    expect_v(0, S_RD1, 32'h0, "clear_rd1");
    expect_v(0, S_RD2, 32'h0, "clear_rd2");
    expect_v(0, S_B1,  32'h0, "clear_busy1");
    expect_v(0, S_B2,  32'h0, "clear_busy2");
    expect_v(0, S_CNT, 32'h0, "clear_count");
    step(0, 0, 0, 0, 16'h0, 3, 2, 0, 0);
    expect_v(0, S_RD1, 32'h0, "clear_r3");
    expect_v(0, S_B2,  32'h0, "clear_r2_busy");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
